// File: rtl/pe_nic_if.sv
// PE register bus plus router-facing link signals for the NIC; the NIC takes the slave view.
interface pe_nic_if #(
    parameter int DATA_WIDTH = 64
);
    // PE register access
    logic [1:0]            addr;
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  nicEn;
    logic                  nicWrEn;

    // router PE port, NIC -> router
    logic                  net_so;
    logic                  net_ro;
    logic [DATA_WIDTH-1:0] net_do;
    logic                  net_polarity;

    // router PE port, router -> NIC
    logic                  net_si;
    logic                  net_ri;
    logic [DATA_WIDTH-1:0] net_di;

    modport slave (
        input  addr, d_in, nicEn, nicWrEn,
        input  net_ro, net_polarity, net_si, net_di,
        output d_out, net_so, net_do, net_ri
    );

    modport master (
        output addr, d_in, nicEn, nicWrEn,
        output net_ro, net_polarity, net_si, net_di,
        input  d_out, net_so, net_do, net_ri
    );
endinterface

// File: rtl/pe_nic.sv
// One-entry in/out channel NIC between a PE register port and a router PE port; reads return next cycle.
// Each buffer blocks when full: net_ri drops on the input side, PE writes are dropped on the output side.
module pe_nic #(
    parameter int DATA_WIDTH = 64
) (
    input  logic     clk,
    input  logic     reset,
    pe_nic_if.slave  nic
);
    localparam int VC_BIT = DATA_WIDTH - 1;

    typedef enum logic {IN_EMPTY  = 1'b0, IN_FULL  = 1'b1} in_state_t;
    typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;

    in_state_t             in_state, in_next;
    out_state_t            out_state, out_next;
    logic [DATA_WIDTH-1:0] in_buf;
    logic [DATA_WIDTH-1:0] out_buf;
    logic [DATA_WIDTH-1:0] d_out_q;
    logic [DATA_WIDTH-1:0] rd_dat;

    logic in_full;
    logic out_full;
    logic rd_en;
    logic wr_en;
    logic rd_in_buf;
    logic wr_out_buf;
    logic in_capture;
    logic out_load;
    logic vc_match;
    logic send;
    logic accept;

    assign in_full  = (in_state == IN_FULL);
    assign out_full = (out_state == OUT_FULL);

    assign rd_en      = nic.nicEn & ~nic.nicWrEn;
    assign wr_en      = nic.nicEn &  nic.nicWrEn;
    assign rd_in_buf  = rd_en & (nic.addr == 2'b00);
    assign wr_out_buf = wr_en & (nic.addr == 2'b10);

    // A packet may only leave on the router cycle whose polarity matches its VC bit.
    assign vc_match = (out_buf[VC_BIT] == nic.net_polarity);
    assign send     = reset & out_full & nic.net_ro & vc_match;
    assign accept   = reset & ~in_full;

    assign nic.net_so = send;
    assign nic.net_ri = accept;
    assign nic.net_do = out_buf;
    assign nic.d_out  = d_out_q;

    always_comb begin
        in_next    = in_state;
        in_capture = 1'b0;
        case (in_state)
            IN_EMPTY: begin
                if (nic.net_si && accept) begin
                    in_next    = IN_FULL;
                    in_capture = 1'b1;
                end
            end
            IN_FULL: begin
                if (rd_in_buf) begin
                    in_next = IN_EMPTY;
                end
            end
            default: in_next = IN_EMPTY;
        endcase
    end

    // out_full is the pre-edge value, so a write on the draining edge is dropped.
    always_comb begin
        out_next = out_state;
        out_load = 1'b0;
        case (out_state)
            OUT_EMPTY: begin
                if (wr_out_buf) begin
                    out_next = OUT_FULL;
                    out_load = 1'b1;
                end
            end
            OUT_FULL: begin
                if (send) begin
                    out_next = OUT_EMPTY;
                end
            end
            default: out_next = OUT_EMPTY;
        endcase
    end

    always_comb begin
        rd_dat = '0;
        case (nic.addr)
            2'b00:   rd_dat = in_buf;
            2'b01:   rd_dat = {{(DATA_WIDTH-1){1'b0}}, in_full};
            2'b10:   rd_dat = '0;
            2'b11:   rd_dat = {{(DATA_WIDTH-1){1'b0}}, out_full};
            default: rd_dat = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_state  <= IN_EMPTY;
            out_state <= OUT_EMPTY;
            in_buf    <= '0;
            out_buf   <= '0;
            d_out_q   <= '0;
        end else begin
            in_state  <= in_next;
            out_state <= out_next;
            if (in_capture) begin
                in_buf <= nic.net_di;
            end
            if (out_load) begin
                out_buf <= nic.d_in;
            end
            if (rd_en) begin
                d_out_q <= rd_dat;
            end
        end
    end
endmodule

// File: tb/tb_pe_nic.sv
// Directed bench for pe_nic: reset, send with polarity, backpressure, receive, input-full, concurrent traffic.
module tb_pe_nic;
    localparam int DW = 64;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [DW-1:0] rd;

    pe_nic_if #(.DATA_WIDTH(DW)) bus ();

    pe_nic #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .nic   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one edge and land 1 ns after it, clear of the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pe_read(input logic [1:0] a, output logic [DW-1:0] data);
        bus.nicEn   = 1'b1;
        bus.nicWrEn = 1'b0;
        bus.addr    = a;
        tick();
        bus.nicEn   = 1'b0;
        data        = bus.d_out;
    endtask

    task automatic pe_write(input logic [1:0] a, input logic [DW-1:0] data);
        bus.nicEn   = 1'b1;
        bus.nicWrEn = 1'b1;
        bus.addr    = a;
        bus.d_in    = data;
        tick();
        bus.nicEn   = 1'b0;
        bus.nicWrEn = 1'b0;
    endtask

    initial begin
        n_checks         = 0;
        n_pass           = 0;
        reset            = 1'b0;
        bus.addr         = 2'b10;
        bus.d_in         = 64'hDEAD_BEEF_0000_0001;
        bus.nicEn        = 1'b1;
        bus.nicWrEn      = 1'b1;
        bus.net_ro       = 1'b1;
        bus.net_polarity = 1'b1;
        bus.net_si       = 1'b1;
        bus.net_di       = 64'h0BAD_0000_0000_0007;

        // Reset held with traffic on both sides.
        tick();
        tick();
        check("rst_d_out", bus.d_out, '0);
        check("rst_net_so", {63'd0, bus.net_so}, 64'd0);
        check("rst_net_ri", {63'd0, bus.net_ri}, 64'd0);

        reset       = 1'b1;
        bus.nicEn   = 1'b0;
        bus.nicWrEn = 1'b0;
        bus.net_si  = 1'b0;
        settle();
        check("rst_rel_ri", {63'd0, bus.net_ri}, 64'd1);
        check("rst_rel_so", {63'd0, bus.net_so}, 64'd0);
        pe_read(2'b01, rd);
        check("rst_in_stat", rd, 64'd0);
        pe_read(2'b11, rd);
        check("rst_out_stat", rd, 64'd0);
        pe_read(2'b00, rd);
        check("rst_in_buf", rd, 64'd0);

        // Send VC=1 packet; it may only leave while polarity=1.
        bus.net_polarity = 1'b0;
        pe_write(2'b10, 64'hC000_0000_1111_1111);
        check("send_wait_pol", {63'd0, bus.net_so}, 64'd0);
        check("send_net_do", bus.net_do, 64'hC000_0000_1111_1111);
        tick();
        bus.net_polarity = 1'b1;
        settle();
        check("send_so_hi", {63'd0, bus.net_so}, 64'd1);
        tick();
        bus.net_polarity = 1'b0;
        settle();
        bus.net_polarity = 1'b1;
        settle();
        check("send_so_once", {63'd0, bus.net_so}, 64'd0);
        pe_read(2'b11, rd);
        check("send_out_stat", rd, 64'd0);

        // Backpressure: router not ready, second write dropped.
        bus.net_ro       = 1'b0;
        bus.net_polarity = 1'b0;
        pe_write(2'b10, 64'h0000_0000_0000_0055);
        check("bp_so_lo", {63'd0, bus.net_so}, 64'd0);
        pe_read(2'b11, rd);
        check("bp_out_stat", rd, 64'd1);
        pe_write(2'b10, 64'h0000_0000_0000_2222);
        check("bp_keep_data", bus.net_do, 64'h0000_0000_0000_0055);
        bus.net_ro = 1'b1;
        settle();
        check("bp_so_hi", {63'd0, bus.net_so}, 64'd1);
        tick();
        check("bp_so_drop", {63'd0, bus.net_so}, 64'd0);
        pe_read(2'b11, rd);
        check("bp_out_empty", rd, 64'd0);

        // Receive, then a second word held while full.
        bus.net_si = 1'b1;
        bus.net_di = 64'hA5A5_0000_0000_0001;
        settle();
        check("rx_ri_ready", {63'd0, bus.net_ri}, 64'd1);
        tick();
        bus.net_di = 64'h0000_0000_0000_0003;
        settle();
        check("rx_ri_drop", {63'd0, bus.net_ri}, 64'd0);
        pe_read(2'b01, rd);
        check("rx_in_stat", rd, 64'd1);
        pe_read(2'b00, rd);
        check("rx_data", rd, 64'hA5A5_0000_0000_0001);
        check("rx_ri_back", {63'd0, bus.net_ri}, 64'd1);
        tick();
        bus.net_si = 1'b0;
        settle();
        check("rx2_ri_drop", {63'd0, bus.net_ri}, 64'd0);
        pe_read(2'b00, rd);
        check("rx2_data", rd, 64'h0000_0000_0000_0003);
        pe_read(2'b00, rd);
        check("rx_stale", rd, 64'h0000_0000_0000_0003);
        check("rx_stale_ri", {63'd0, bus.net_ri}, 64'd1);
        pe_read(2'b10, rd);
        check("rd_outbuf_zero", rd, 64'd0);

        // Concurrent send and receive; PE write on the draining edge is dropped.
        bus.net_polarity = 1'b1;
        bus.net_ro       = 1'b1;
        bus.net_si       = 1'b1;
        bus.net_di       = 64'h0000_0000_0000_1234;
        pe_write(2'b10, 64'h8000_0000_0000_00AA);
        bus.net_si = 1'b0;
        settle();
        check("cc_ri_lo", {63'd0, bus.net_ri}, 64'd0);
        check("cc_so_hi", {63'd0, bus.net_so}, 64'd1);
        check("cc_net_do", bus.net_do, 64'h8000_0000_0000_00AA);
        pe_write(2'b10, 64'h8000_0000_0000_9999);
        check("cc_so_done", {63'd0, bus.net_so}, 64'd0);
        pe_read(2'b11, rd);
        check("cc_drain_wr_drop", rd, 64'd0);
        pe_read(2'b00, rd);
        check("cc_rx_data", rd, 64'h0000_0000_0000_1234);

        // Reset while a packet waits discards it.
        bus.net_ro = 1'b0;
        pe_write(2'b10, 64'h8000_0000_0000_0077);
        reset = 1'b0;
        tick();
        reset      = 1'b1;
        bus.net_ro = 1'b1;
        settle();
        check("rst_mid_so", {63'd0, bus.net_so}, 64'd0);
        check("rst_mid_do", bus.net_do, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pe_nic.md
Name: pe_nic

Overview:
- Network interface controller between a processing element (PE) and the PE port of one mesh router.
- Provides the PE with a memory-mapped register interface: one-entry input channel buffer, one-entry output channel buffer, and a status register for each.
- Router side uses the same si/ri/di and so/ro/do handshake as the router links, plus the router's polarity output.
- Net output side drives the router's pesi/pedi/peri port; net input side consumes the router's peso/pero/pedo port.

Parameters:
- DATA_WIDTH, 64, packet width. Bit 63 = VC bit; 62:61 = direction; 55:48 = hop field; 47:32 = source; 31:0 = payload. The NIC passes all fields through untouched.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-low reset
- addr  input  2  PE register address
- d_in  input  DATA_WIDTH  PE write data
- d_out  output  DATA_WIDTH  PE read data (registered)
- nicEn  input  1  PE access enable
- nicWrEn  input  1  1 = write, 0 = read (qualified by nicEn)
- net_so  output  1  send to router (drives router pesi)
- net_ro  input  1  router ready to accept (router peri)
- net_do  output  DATA_WIDTH  data to router (router pedi)
- net_polarity  input  1  router polarity
- net_si  input  1  router sending to NIC (router peso)
- net_ri  output  1  NIC ready to accept (router pero)
- net_di  input  DATA_WIDTH  data from router (router pedo)

Behaviour:
- Register map:
  - 00 = input buffer, read-only.
  - 01 = input status, read-only; bit0 = in_full, other bits 0.
  - 10 = output buffer, write-only.
  - 11 = output status, read-only; bit0 = out_full, other bits 0.
- Writes to 00/01/11 are ignored. A read of 10 returns 0.
- Reset (reset==0 at an edge): in_full=0, out_full=0, in_buf=0, out_buf=0, d_out=0. While reset is low, net_so=0 and net_ri=0. Reset mid-transfer discards both buffers, with no partial send.
- PE read: nicEn=1, nicWrEn=0 at edge N → d_out holds the selected register value from edge N (1-cycle latency). Without a read, d_out holds its last value.
- Input channel (two-state FSM, EMPTY/FULL via in_full):
  - net_ri = reset & ~in_full, combinational from the flag.
  - EMPTY→FULL: at an edge with net_si=1 and net_ri=1, in_buf<=net_di.
  - FULL→EMPTY: at the edge where the PE reads addr 00; d_out<=in_buf on the same edge.
  - net_si while FULL is not accepted; the router holds its data.
  - Reading addr 00 while EMPTY returns the stale in_buf and leaves state unchanged.
- Output channel (two-state FSM via out_full):
  - EMPTY→FULL: at the edge where nicEn=1, nicWrEn=1, addr=10 and out_full=0; out_buf<=d_in.
  - Write while FULL is ignored; out_buf is unchanged and no error is raised. The PE must poll addr 11.
  - net_do = out_buf at all times.
  - net_so = reset & out_full & net_ro & (out_buf[63]==net_polarity), combinational.
  - FULL→EMPTY: at the edge where net_so=1. Exactly one transfer per packet.
  - A packet whose VC bit mismatches polarity waits; with polarity toggling each cycle, the added wait is at most 1 cycle.
- Simultaneous events:
  - A PE write on the same edge the buffer drains is ignored, because out_full is sampled before the edge.
  - Input capture and PE read of addr 00 cannot coincide, because net_ri=0 while FULL.
  - Input and output channels operate fully independently in the same cycle.
- Latency:
  - PE write to net_so high: ≥1 cycle (next cycle if net_ro=1 and polarity matches).
  - Router capture to in_full visible via status read: 2 edges.

Test Plan:
- Reset: hold reset=0 for 2 cycles with net_si=1 and PE write to 10 → d_out=0, net_so=0, net_ri=0, both status regs read 0 after release, no capture.
- Send: write d_in=64'hC000_0000_1111_1111 (VC=1) to addr 10 with net_ro=1 and polarity toggling → net_so high for exactly 1 cycle, only when polarity=1. net_do=64'hC000_0000_1111_1111, then addr 11 reads 0.
- Backpressure: net_ro=0 after write → net_so stays 0 and addr 11 reads 1. A second write of 64'h2222 is ignored. Raise net_ro → the first packet is sent unchanged.
- Receive: net_si=1 with net_di=64'hA5A5_0000_0000_0001 → net_ri drops the next cycle and addr 01 reads 1. Read addr 00 → d_out=64'hA5A5_0000_0000_0001, then net_ri returns to 1.
- Input full: net_si held at 1 with a second word 64'h3 while the buffer is FULL → not captured. After the PE read of 00, 64'h3 is captured on the next edge.
- Concurrent: send and receive in the same cycles → both complete, with no interference in data or flags.
